// File: rtl/frodo_host_seq.sv
// Host-side run sequencer for the Frodo core: accepts one command, pulses start,
// times the run until completion/abort/timeout and returns a status response.
module frodo_host_seq #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 100000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_level,
    input  logic [1:0]           cmd_mode,
    input  logic                 abort,
    output logic                 core_start,
    output logic [1:0]           core_level,
    output logic [1:0]           core_mode,
    input  logic                 core_valid,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_status,
    output logic [CNT_WIDTH-1:0] rsp_cycles,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 valid_q;
    logic                 complete;

    // The counter value "seen" in a RUN cycle is the incremented one, so the
    // first RUN cycle reports 1 even though LAUNCH clears the register to 0.
    assign count_inc = count + CNT_WIDTH'(1);
    assign complete  = core_valid & ~valid_q;

    assign cmd_ready  = (state == S_IDLE);
    assign core_start = (state == S_LAUNCH);
    assign busy       = (state == S_LAUNCH) || (state == S_RUN);
    assign rsp_valid  = (state == S_RESP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            count      <= '0;
            valid_q    <= 1'b0;
            core_level <= '0;
            core_mode  <= '0;
            rsp_status <= '0;
            rsp_cycles <= '0;
        end else begin
            valid_q <= core_valid;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        core_level <= cmd_level;
                        core_mode  <= cmd_mode;
                        if ((cmd_level == 2'd3) || (cmd_mode == 2'd3)) begin
                            rsp_status <= ST_ILLEGAL;
                            rsp_cycles <= '0;
                            state      <= S_RESP;
                        end else begin
                            state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    count <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    count <= count_inc;
                    if (complete) begin
                        rsp_status <= ST_OK;
                        rsp_cycles <= count_inc;
                        state      <= S_RESP;
                    end else if (abort) begin
                        rsp_status <= ST_ABORT;
                        rsp_cycles <= count_inc;
                        state      <= S_RESP;
                    end else if (count_inc == TIMEOUT_CNT) begin
                        rsp_status <= ST_TIMEOUT;
                        rsp_cycles <= TIMEOUT_CNT;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frodo_host_seq.sv
// Directed bench for frodo_host_seq: per-run expectations derived from the
// command/timeline, checked against the DUT on every falling clock edge.
module tb_frodo_host_seq;

    localparam int unsigned CW  = 16;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_level = 2'd0;
    logic [1:0]    cmd_mode = 2'd0;
    logic          abort = 1'b0;
    logic          core_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic          cmd_ready;
    logic          core_start;
    logic [1:0]    core_level;
    logic [1:0]    core_mode;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic [CW-1:0] rsp_cycles;
    logic          busy;

    frodo_host_seq #(.CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_level(cmd_level), .cmd_mode(cmd_mode),
        .abort(abort),
        .core_start(core_start), .core_level(core_level), .core_mode(core_mode),
        .core_valid(core_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_cycles(rsp_cycles),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic        e_ready = 1'b1;
    logic        e_start = 1'b0;
    logic        e_busy = 1'b0;
    logic        e_rvalid = 1'b0;
    logic [1:0]  e_level = 2'd0;
    logic [1:0]  e_mode = 2'd0;
    logic [1:0]  e_status = 2'd0;
    logic [31:0] e_cycles = 32'd0;
    int          checks = 0;
    int          failures = 0;
    bit          running = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            chk("cmd_ready",  32'(cmd_ready),  32'(e_ready));
            chk("core_start", 32'(core_start), 32'(e_start));
            chk("busy",       32'(busy),       32'(e_busy));
            chk("rsp_valid",  32'(rsp_valid),  32'(e_rvalid));
            chk("core_level", 32'(core_level), 32'(e_level));
            chk("core_mode",  32'(core_mode),  32'(e_mode));
            if (e_rvalid) begin
                chk("rsp_status", 32'(rsp_status), 32'(e_status));
                chk("rsp_cycles", 32'(rsp_cycles), e_cycles);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        e_ready  = 1'b1;
        e_start  = 1'b0;
        e_busy   = 1'b0;
        e_rvalid = 1'b0;
    endtask

    // ev: RUN cycle of the core_valid rising edge (0 = never); ab: RUN cycle with
    // abort (0 = never); fall: core_valid starts high and drops in this RUN cycle
    // (0 = starts low); keep: leave core_valid high after the run.
    task automatic run(input logic [1:0] lvl, input logic [1:0] md,
                       input int ev, input int ab, input int fall, input bit keep,
                       input int rdly, input logic [1:0] lit_st, input int lit_cyc);
        int         k;
        logic [1:0] st;
        abort      = 1'b1;
        core_valid = (fall > 0);
        tick();
        tick();
        cmd_valid = 1'b1;
        cmd_level = lvl;
        cmd_mode  = md;
        tick();
        cmd_valid = 1'b0;
        cmd_level = ~lvl;
        cmd_mode  = ~md;
        e_level   = lvl;
        e_mode    = md;
        e_ready   = 1'b0;
        k  = 0;
        st = 2'b00;
        if (lvl == 2'd3 || md == 2'd3) begin
            st = 2'b10;
        end else begin
            e_start = 1'b1;
            e_busy  = 1'b1;
            tick();
            e_start = 1'b0;
            for (int n = 1; n <= int'(TMO) && k == 0; n++) begin
                if (n == ev) begin
                    k = n; st = 2'b00;
                end else if (n == ab) begin
                    k = n; st = 2'b11;
                end else if (n == int'(TMO)) begin
                    k = n; st = 2'b01;
                end
            end
            for (int n = 1; n <= k; n++) begin
                abort      = (n == ab);
                core_valid = (ev > 0 && n >= ev) || (n < fall);
                tick();
            end
            e_busy = 1'b0;
        end
        e_rvalid   = 1'b1;
        e_status   = st;
        e_cycles   = 32'(k);
        abort      = 1'b1;
        core_valid = keep;
        chk("rsp_status_lit", 32'(rsp_status), 32'(lit_st));
        chk("rsp_cycles_lit", 32'(rsp_cycles), 32'(lit_cyc));
        for (int i = 0; i < rdly; i++) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        abort     = 1'b0;
        set_idle_exp();
    endtask

    task automatic reset_mid_run();
        abort      = 1'b0;
        core_valid = 1'b0;
        cmd_valid  = 1'b1;
        cmd_level  = 2'd2;
        cmd_mode   = 2'd1;
        tick();
        cmd_valid = 1'b0;
        e_level   = 2'd2;
        e_mode    = 2'd1;
        e_ready   = 1'b0;
        e_start   = 1'b1;
        e_busy    = 1'b1;
        tick();
        e_start = 1'b0;
        for (int n = 1; n < 30; n++) tick();
        #2;
        rstn = 1'b0;
        set_idle_exp();
        e_level = 2'd0;
        e_mode  = 2'd0;
        #1;
        chk("async_busy",      32'(busy),       32'd0);
        chk("async_start",     32'(core_start), 32'd0);
        chk("async_level",     32'(core_level), 32'd0);
        chk("async_cmd_ready", 32'(cmd_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        tick();
        chk("post_reset_cycles", 32'(rsp_cycles), 32'd0);
    endtask

    initial begin
        running = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        chk("reset_cmd_ready",  32'(cmd_ready),  32'd1);
        chk("reset_rsp_status", 32'(rsp_status), 32'd0);
        chk("reset_rsp_cycles", 32'(rsp_cycles), 32'd0);
        chk("reset_core_mode",  32'(core_mode),  32'd0);

        run(2'd1, 2'd0, 50, 0, 0, 1'b0, 0, 2'b00, 50);
        run(2'd3, 2'd0, 0, 0, 0, 1'b0, 5, 2'b10, 0);
        run(2'd0, 2'd3, 0, 0, 0, 1'b0, 0, 2'b10, 0);
        run(2'd2, 2'd1, 0, 0, 0, 1'b0, 1, 2'b01, 64);
        run(2'd0, 2'd2, 64, 0, 0, 1'b0, 0, 2'b00, 64);
        run(2'd1, 2'd1, 0, 7, 0, 1'b0, 0, 2'b11, 7);
        run(2'd2, 2'd2, 7, 7, 0, 1'b0, 0, 2'b00, 7);
        run(2'd0, 2'd0, 1, 0, 0, 1'b0, 0, 2'b00, 1);
        run(2'd1, 2'd2, 10, 0, 0, 1'b1, 2, 2'b00, 10);
        run(2'd0, 2'd1, 12, 0, 3, 1'b0, 0, 2'b00, 12);
        reset_mid_run();
        run(2'd2, 2'd0, 5, 0, 0, 1'b0, 0, 2'b00, 5);

        tick();
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
